// File: rtl/comparator_bank.sv
// Multi-lane unsigned comparator bank: per-lane GT/GE/EQ/WINDOW compare, debounced over STABLE_CYCLES samples,
// with registered match level, rise/fall pulses and a software-clearable sticky flag.
module comparator_bank #(
  parameter int WIDTH         = 10,
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_en,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] value_a,
  input  logic [CHANNELS*WIDTH-1:0] value_b,
  input  logic [CHANNELS*WIDTH-1:0] value_hi,
  input  logic [CHANNELS-1:0]       clear_sticky,
  output logic [CHANNELS-1:0]       match,
  output logic [CHANNELS-1:0]       rise,
  output logic [CHANNELS-1:0]       fall,
  output logic [CHANNELS-1:0]       sticky,
  output logic                      any_match
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // Counter value at which the next disagreeing sample completes the run.
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [1:0]                   mode_q;
  logic [CHANNELS-1:0]          match_q, match_d;
  logic [CHANNELS-1:0]          rise_q, rise_d;
  logic [CHANNELS-1:0]          fall_q, fall_d;
  logic [CHANNELS-1:0]          sticky_q, sticky_d;
  logic [CHANNELS-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]          cmp;
  logic                         mode_chg;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [WIDTH-1:0] a, b, hi;
    assign a  = value_a[g*WIDTH +: WIDTH];
    assign b  = value_b[g*WIDTH +: WIDTH];
    assign hi = value_hi[g*WIDTH +: WIDTH];
    // An inverted window (b > hi) can never satisfy both bounds, so it yields 0 naturally.
    assign cmp[g] = (mode == 2'd0) ? (a > b)  :
                    (mode == 2'd1) ? (a >= b) :
                    (mode == 2'd2) ? (a == b) :
                                     ((a >= b) && (a <= hi));
  end

  assign mode_chg = (mode != mode_q);

  always_comb begin
    match_d = match_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode_chg) begin
        cnt_d[i] = '0;
      end else if (sample_en) begin
        if (cmp[i] == match_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          match_d[i] = cmp[i];
          cnt_d[i]   = '0;
          rise_d[i]  = cmp[i];
          fall_d[i]  = ~cmp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // A rise on the same edge as a clear wins.
    sticky_d = (sticky_q & ~clear_sticky) | rise_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= '0;
      match_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      mode_q   <= mode;
      match_q  <= match_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign match     = match_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign sticky    = sticky_q;
  assign any_match = |match_q;

endmodule

// File: tb/tb_comparator_bank.sv
// Bench for comparator_bank: directed scenarios with literal expectations plus randomized traffic,
// all cycles checked against a history-based reference model.
module tb_comparator_bank;
  localparam int W  = 10;
  localparam int CH = 4;
  localparam int S  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            sample_en;
  logic [1:0]      mode;
  logic [CH*W-1:0] va, vb, vh;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   match, rise, fall, sticky;
  logic            any_match;

  int tests = 0;
  int fails = 0;
  bit running = 1'b1;

  comparator_bank #(.WIDTH(W), .CHANNELS(CH), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .mode(mode),
    .value_a(va), .value_b(vb), .value_hi(vh), .clear_sticky(clr),
    .match(match), .rise(rise), .fall(fall), .sticky(sticky), .any_match(any_match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a lane flips when its last S samples since the previous
  // flip / mode change / reset all disagree with the current level.
  bit [CH-1:0] m_match, m_rise, m_fall, m_sticky;
  bit [1:0]    m_mode;
  bit [31:0]   hbits [CH];
  int          hlen  [CH];

  function automatic bit ref_cmp(input int md, input int a, input int b, input int hi);
    case (md)
      0:       return a > b;
      1:       return a >= b;
      2:       return a == b;
      default: return (a >= b) && (a <= hi);
    endcase
  endfunction

  function automatic int lane(input logic [CH*W-1:0] v, input int i);
    return int'(v[i*W +: W]);
  endfunction

  always @(posedge clk) begin : model
    bit c, flip;
    if (reset) begin
      m_match = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_mode = '0;
      for (int i = 0; i < CH; i++) hlen[i] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      if (mode != m_mode) begin
        for (int i = 0; i < CH; i++) hlen[i] = 0;
      end else if (sample_en) begin
        for (int i = 0; i < CH; i++) begin
          c = ref_cmp(int'(mode), lane(va, i), lane(vb, i), lane(vh, i));
          hbits[i] = {hbits[i][30:0], c};
          hlen[i]++;
          if (hlen[i] >= S) begin
            flip = 1'b1;
            for (int k = 0; k < S; k++) if (hbits[i][k] == m_match[i]) flip = 1'b0;
            if (flip) begin
              m_match[i] = c;
              m_rise[i]  = c;
              m_fall[i]  = ~c;
              hlen[i]    = 0;
            end
          end
        end
      end
      m_sticky = (m_sticky & ~clr) | m_rise;
      m_mode   = mode;
    end
    #1;
    if (running) begin
      chk("match",     int'(match),     int'(m_match));
      chk("rise",      int'(rise),      int'(m_rise));
      chk("fall",      int'(fall),      int'(m_fall));
      chk("sticky",    int'(sticky),    int'(m_sticky));
      chk("any_match", int'(any_match), int'(|m_match));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set0(input int a, input int b, input int hi);
    va[W-1:0] = W'(a);
    vb[W-1:0] = W'(b);
    vh[W-1:0] = W'(hi);
  endtask

  initial begin
    reset = 1'b1;
    sample_en = 1'b1;
    mode = 2'($urandom);
    va = 40'({$urandom, $urandom});
    vb = 40'({$urandom, $urandom});
    vh = 40'({$urandom, $urandom});
    clr = 4'($urandom);
    tick(2);
    chk("rst_match", int'(match), 0);
    chk("rst_rise", int'(rise), 0);
    chk("rst_fall", int'(fall), 0);
    chk("rst_sticky", int'(sticky), 0);
    chk("rst_any", int'(any_match), 0);

    // Reset in the middle of a count discards the partial run.
    mode = 2'd0; va = '0; vb = '0; vh = '0; clr = '0;
    set0(512, 256, 0);
    reset = 1'b0;
    tick(1); chk("t1_one_sample", int'(match[0]), 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1); chk("t1_post_rst_1", int'(match[0]), 0);
    tick(1);
    chk("t2_match", int'(match[0]), 1);
    chk("t2_rise", int'(rise[0]), 1);
    chk("t2_sticky", int'(sticky[0]), 1);
    chk("t2_any", int'(any_match), 1);
    chk("t2_others", int'(match[3:1]), 0);
    tick(1); chk("t2_rise_1cyc", int'(rise[0]), 0);

    // Mode switching.
    set0(256, 256, 0);
    tick(2);
    chk("t3_gt_eq_fall", int'(fall[0]), 1);
    chk("t3_gt_eq_match", int'(match[0]), 0);
    mode = 2'd1;
    tick(1); chk("t3_mode_edge", int'(match[0]), 0);
    tick(1); chk("t3_ge_1", int'(match[0]), 0);
    tick(1); chk("t3_ge_2", int'(match[0]), 1);
    mode = 2'd2; set0(1023, 1023, 0);
    tick(2); chk("t3_eq_max", int'(match[0]), 1);
    mode = 2'd1; set0(0, 1023, 0);
    tick(3); chk("t3_ge_false", int'(match[0]), 0);

    // Glitch rejection and sample gaps.
    mode = 2'd0; set0(0, 0, 0);
    tick(1);
    set0(512, 256, 0); tick(1);
    set0(0, 256, 0);   tick(1);
    chk("t4_glitch_match", int'(match[0]), 0);
    chk("t4_glitch_rise", int'(rise[0]), 0);
    set0(512, 256, 0); tick(1);
    sample_en = 1'b0;  tick(3);
    chk("t4_gap_hold", int'(match[0]), 0);
    sample_en = 1'b1;  tick(1);
    chk("t4_gap_match", int'(match[0]), 1);
    chk("t4_gap_rise", int'(rise[0]), 1);

    // Window bounds.
    mode = 2'd3; set0(100, 100, 200);
    tick(2); chk("t5_low_edge", int'(match[0]), 1);
    set0(200, 100, 200);
    tick(2); chk("t5_high_edge", int'(match[0]), 1);
    set0(201, 100, 200);
    tick(1); chk("t5_201_once", int'(match[0]), 1);
    tick(1);
    chk("t5_201_match", int'(match[0]), 0);
    chk("t5_201_fall", int'(fall[0]), 1);
    set0(300, 300, 200);
    tick(4); chk("t5_inverted", int'(match[0]), 0);

    // Sticky set/clear interaction.
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("t6_cleared", int'(sticky[0]), 0);
    mode = 2'd0; set0(512, 256, 0);
    tick(2);
    clr[0] = 1'b1;
    tick(1);
    chk("t6_set_wins_rise", int'(rise[0]), 1);
    chk("t6_set_wins", int'(sticky[0]), 1);
    tick(1);
    chk("t6_clear_only", int'(sticky[0]), 0);
    chk("t6_match_held", int'(match[0]), 1);
    clr = '0;

    // Randomized traffic; small operand range makes equality and bounds frequent.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) mode = 2'($urandom);
      sample_en = ($urandom_range(3) != 0);
      clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < CH; i++) begin
          if ($urandom_range(1) == 0) begin
            va[i*W +: W] = W'($urandom_range(7));
            vb[i*W +: W] = W'($urandom_range(7));
            vh[i*W +: W] = W'($urandom_range(7));
          end else begin
            va[i*W +: W] = W'($urandom);
            vb[i*W +: W] = W'($urandom);
            vh[i*W +: W] = W'($urandom);
          end
        end
      end
      tick(1);
    end

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comparator_bank.md
Name: comparator_bank

Overview:
- Parametrised, multi-channel successor to the single registered A>B comparator used for Frogger position and collision checks.
- Each of CHANNELS lanes compares unsigned WIDTH-bit operands under a run-time selectable mode.
- Each lane debounces its result over STABLE_CYCLES consecutive samples and produces a level, rise/fall pulses and a software-clearable sticky flag.
- Sits between the object-position registers and the game FSM, which consumes any_match / sticky.

Parameters:
WIDTH, 10, operand width in bits (unsigned)
CHANNELS, 4, number of independent compare lanes
STABLE_CYCLES, 2, consecutive disagreeing samples needed to flip a lane's match (>=1; counter width $clog2(STABLE_CYCLES+1))

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
sample_en  in  1  qualifies the current inputs as a sample
mode  in  2  0=GT (a>b), 1=GE (a>=b), 2=EQ (a==b), 3=WINDOW (b<=a<=hi)
value_a  in  CHANNELS*WIDTH  lane i operand a at bits [i*WIDTH +: WIDTH]
value_b  in  CHANNELS*WIDTH  lane i operand b / window low bound
value_hi  in  CHANNELS*WIDTH  lane i window high bound (ignored unless mode=3)
clear_sticky  in  CHANNELS  per-lane sticky clear
match  out  CHANNELS  debounced compare level
rise  out  CHANNELS  one-cycle pulse when match goes 0->1
fall  out  CHANNELS  one-cycle pulse when match goes 1->0
sticky  out  CHANNELS  set on rise, held until cleared
any_match  out  1  OR of match (combinational from registers)

Behaviour:
- Reset (clk edge with reset=1): match, rise, fall, sticky, per-lane counters and mode_q all 0. Reset overrides every other input, including a reset asserted mid-count.
- cmp[i] is combinational from mode, a, b, hi. All comparisons are unsigned and full-width.
- WINDOW is inclusive at both ends. If b>hi, cmp=0.
- Registered mode copy mode_q updates on every non-reset edge.
- If mode != mode_q on an edge:
  - all counters clear to 0;
  - that sample is not counted;
  - match and sticky hold;
  - rise/fall are 0.
- On an edge with sample_en=1 and mode==mode_q, per lane:
  - cmp==match: cnt<=0.
  - cmp!=match and cnt+1<STABLE_CYCLES: cnt<=cnt+1.
  - cmp!=match and cnt+1==STABLE_CYCLES: match<=cmp, cnt<=0, and rise<=cmp or fall<=~cmp for exactly that cycle.
- sample_en=0: counters and match hold; rise/fall <=0. Non-consecutive samples still count as consecutive; gaps do not reset the count.
- Latency:
  - STABLE_CYCLES=1: match updates on the edge that samples the input, giving 1-cycle registered behaviour identical to the legacy comparator in GT mode.
  - General case: match flips on the edge capturing the STABLE_CYCLES-th consecutive disagreeing sample.
- rise/fall are registered, asserted in the same cycle match changes, and never both high.
- sticky[i]:
  - Next value = (sticky & ~clear_sticky) | rise_next.
  - Set wins over a simultaneous clear.
  - Clearing while match remains 1 leaves sticky 0 until the next rise.
- Counter saturation cannot occur (it clears on reaching STABLE_CYCLES). A glitch shorter than STABLE_CYCLES samples produces no output change.
- Lanes are fully independent except for the shared mode and sample_en.

Test Plan (defaults WIDTH=10, CHANNELS=4, STABLE_CYCLES=2):
1. Reset: hold reset 2 cycles with random inputs -> match=rise=fall=sticky=0, any_match=0. Assert reset mid-count (after 1 true sample) -> counter cleared; after release, 2 more true samples are needed.
2. GT, lane0 a=512 b=256, sample_en=1 held -> match[0]=1 on 2nd sampling edge; rise[0] high exactly 1 cycle; sticky[0]=1; any_match=1; lanes 1-3 stay 0.
3. a=256 b=256: GT -> match 0; switch to GE -> first edge only updates mode_q, match[0] rises 2 samples later. EQ with a=b=1023 -> match=1; a=0 b=1023 GE -> 0.
4. Glitch rejection: GT true for 1 sample, false next -> no match/rise. Then true, sample_en=0 for 3 cycles, true again -> match rises on the second sampled edge.
5. WINDOW b=100 hi=200: a=100 and a=200 -> match; a=201 for 2 samples -> fall pulse, match=0. b=300 hi=200 -> never matches.
6. Sticky: clear_sticky[0]=1 on the same edge as rise[0] -> sticky stays 1. clear_sticky alone next cycle -> sticky 0 while match stays 1.
